// File: rtl/cmip_irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : cmip_irq_sched
// Brief    : Round-robin interrupt-to-MSI scheduler with per-interrupt holdoff.
//            Optional macro IRQ_SCHED_RETRY_EN: up to 3 MSI attempts per grant.
// Revision : 1.0
// ============================================================================
module cmip_irq_sched #(
    parameter int DATA_WDTH = 32,
    parameter int VEC_WDTH  = 5,
    parameter int HOLD_WDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_WDTH-1:0] i_pend,
    input  logic [DATA_WDTH-1:0] i_mask,
    input  logic [HOLD_WDTH-1:0] i_holdoff_cyc,
    output logic                 o_msi_req,
    output logic [VEC_WDTH-1:0]  o_msi_vec,
    input  logic                 i_msi_ack,
    input  logic                 i_msi_fail,
    output logic [DATA_WDTH-1:0] o_clr,
    output logic                 o_busy,
    output logic [15:0]          o_sent_cnt,
    output logic [15:0]          o_drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RETRY = 3'd2,
        S_CLR   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [VEC_WDTH-1:0]   grant_q, grant_d;
    logic [VEC_WDTH-1:0]   last_q, last_d;
    logic [HOLD_WDTH-1:0]  hold_q, hold_d;
    logic [15:0]           sent_q, sent_d;
    logic [15:0]           drop_q, drop_d;
`ifdef IRQ_SCHED_RETRY_EN
    logic [1:0]            att_q, att_d;
`endif

    logic [DATA_WDTH-1:0]  w_elig;
    logic                  w_hi_found;
    logic [VEC_WDTH-1:0]   w_hi_idx;
    logic [VEC_WDTH-1:0]   w_lo_idx;
    logic [VEC_WDTH-1:0]   w_winner;
    logic [15:0]           w_sent_inc;
    logic [15:0]           w_drop_inc;

    assign w_elig     = i_pend & ~i_mask;
    assign w_sent_inc = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;
    assign w_drop_inc = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

    // Lowest eligible index above last_q wins; otherwise wrap to lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = DATA_WDTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lo_idx = VEC_WDTH'(i);
                if (i > int'(last_q)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = VEC_WDTH'(i);
                end
            end
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;
        sent_d  = sent_q;
        drop_d  = drop_q;
`ifdef IRQ_SCHED_RETRY_EN
        att_d   = att_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|w_elig) begin
                    grant_d = w_winner;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_msi_ack) begin
                    sent_d  = w_sent_inc;
                    state_d = S_CLR;
                end else if (i_msi_fail) begin
`ifdef IRQ_SCHED_RETRY_EN
                    if (att_q == 2'd2) begin
                        drop_d  = w_drop_inc;
                        state_d = S_CLR;
                    end else begin
                        att_d   = att_q + 2'd1;
                        state_d = S_RETRY;
                    end
`else
                    drop_d  = w_drop_inc;
                    state_d = S_CLR;
`endif
                end
            end
            S_RETRY: state_d = S_REQ;
            S_CLR: begin
                last_d  = grant_q;
                hold_d  = i_holdoff_cyc;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // A zero or one count both leave after this cycle.
                if (hold_q <= HOLD_WDTH'(1)) begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - HOLD_WDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef IRQ_SCHED_RETRY_EN
        if (state_d == S_CLR) begin
            att_d = '0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= VEC_WDTH'(DATA_WDTH - 1);
            hold_q  <= '0;
            sent_q  <= '0;
            drop_q  <= '0;
`ifdef IRQ_SCHED_RETRY_EN
            att_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            sent_q  <= sent_d;
            drop_q  <= drop_d;
`ifdef IRQ_SCHED_RETRY_EN
            att_q   <= att_d;
`endif
        end
    end

    assign o_msi_req  = (state_q == S_REQ);
    assign o_busy     = (state_q != S_IDLE);
    assign o_clr      = (state_q == S_CLR) ? (DATA_WDTH'(1'b1) << grant_q) : '0;
    assign o_msi_vec  = grant_q;
    assign o_sent_cnt = sent_q;
    assign o_drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_cmip_irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmip_irq_sched
// Brief    : Scoreboard bench for cmip_irq_sched (honours IRQ_SCHED_RETRY_EN).
// Revision : 1.0
// ============================================================================
module tb_cmip_irq_sched;
    localparam int DW = 32;
    localparam int VW = 5;
    localparam int HW = 16;
`ifdef IRQ_SCHED_RETRY_EN
    localparam int MAX_TRY = 3;
`else
    localparam int MAX_TRY = 1;
`endif

    logic          clk;
    logic          i_rst;
    logic [DW-1:0] i_pend;
    logic [DW-1:0] i_mask;
    logic [HW-1:0] i_holdoff_cyc;
    logic          o_msi_req;
    logic [VW-1:0] o_msi_vec;
    logic          i_msi_ack;
    logic          i_msi_fail;
    logic [DW-1:0] o_clr;
    logic          o_busy;
    logic [15:0]   o_sent_cnt;
    logic [15:0]   o_drop_cnt;

    cmip_irq_sched #(.DATA_WDTH(DW), .VEC_WDTH(VW), .HOLD_WDTH(HW)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_pend        (i_pend),
        .i_mask        (i_mask),
        .i_holdoff_cyc (i_holdoff_cyc),
        .o_msi_req     (o_msi_req),
        .o_msi_vec     (o_msi_vec),
        .i_msi_ack     (i_msi_ack),
        .i_msi_fail    (i_msi_fail),
        .o_clr         (o_clr),
        .o_busy        (o_busy),
        .o_sent_cnt    (o_sent_cnt),
        .o_drop_cnt    (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int exp_q[$];
    int model_last = DW - 1;

    bit resp_en    = 1'b0;
    int resp_delay = 0;
    int fail_pct   = 0;
    bit resp_both  = 1'b0;
    bit hold_pend  = 1'b0;
    int exp_sent   = 0;
    int exp_drop   = 0;
    int req_rises  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arbitration: next eligible source after 'last', cyclically.
    function automatic int next_grant(input logic [DW-1:0] elig, input int last);
        int idx;
        for (int k = 1; k <= DW; k++) begin
            idx = (last + k) % DW;
            if (|(elig & (DW'(1) << idx))) return idx;
        end
        return -1;
    endfunction

    // Interrupt-controller stand-in: a clear pulse drops the pending flag.
    task automatic tick();
        @(negedge clk);
        if (!hold_pend) i_pend = i_pend & ~o_clr;
    endtask

    task automatic load(input logic [DW-1:0] p, input logic [DW-1:0] m);
        logic [DW-1:0] e;
        int g;
        i_pend = p;
        i_mask = m;
        e = p & ~m;
        while (e != '0) begin
            g = next_grant(e, model_last);
            exp_q.push_back(g);
            e = e & ~(DW'(1) << g);
            model_last = g;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((o_busy || (i_pend & ~i_mask) != '0 || exp_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check(name, 64'(n < 3000), 64'd1);
    endtask

    task automatic do_reset();
        i_rst  = 1'b1;
        i_pend = '0;
        tick();
        tick();
        i_rst = 1'b0;
        model_last = DW - 1;
    endtask

    // MSI endpoint: answers each request after a delay, tracks expected counters.
    initial begin : responder
        bit prev_req;
        int wait_cnt;
        int tgt;
        int fail_run;
        prev_req = 1'b0; wait_cnt = 0; tgt = 0; fail_run = 0;
        i_msi_ack = 1'b0; i_msi_fail = 1'b0;
        forever begin
            @(negedge clk);
            i_msi_ack  = 1'b0;
            i_msi_fail = 1'b0;
            if (i_rst) begin
                exp_sent = 0; exp_drop = 0; fail_run = 0;
            end
            if (o_msi_req && !prev_req) begin
                req_rises++;
                wait_cnt = 0;
                tgt = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
            end
            if (o_msi_req && resp_en) begin
                if (wait_cnt == tgt) begin
                    if (resp_both) begin
                        i_msi_ack = 1'b1; i_msi_fail = 1'b1;
                        exp_sent++; fail_run = 0;
                    end else if (int'($urandom_range(0, 99)) < fail_pct) begin
                        i_msi_fail = 1'b1;
                        fail_run++;
                        if (fail_run >= MAX_TRY) begin
                            exp_drop++; fail_run = 0;
                        end
                    end else begin
                        i_msi_ack = 1'b1;
                        exp_sent++; fail_run = 0;
                    end
                end
                wait_cnt++;
            end
            prev_req = o_msi_req;
        end
    end

    initial begin : monitor
        bit            prev_req;
        logic [VW-1:0] prev_vec;
        int            g;
        prev_req = 1'b0; prev_vec = '0;
        forever begin
            @(negedge clk);
            if (o_msi_req && prev_req) check("vec_stable", 64'(o_msi_vec), 64'(prev_vec));
            if (o_clr != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_clr", 64'(o_clr), 64'd0);
                end else begin
                    g = exp_q.pop_front();
                    check("clr_onehot", 64'(o_clr), 64'(1) << g);
                    check("clr_vec", 64'(o_msi_vec), 64'(g));
                    check("sent_cnt", 64'(o_sent_cnt), 64'(exp_sent));
                    check("drop_cnt", 64'(o_drop_cnt), 64'(exp_drop));
                end
            end
            prev_req = o_msi_req;
            prev_vec = o_msi_vec;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        int c1, c2, n, clrs, rises0, sent0, drop0;
        logic [DW-1:0] p, m;
        i_rst = 1'b1; i_pend = '0; i_mask = '0; i_holdoff_cyc = '0;
        tick();
        tick();
        check("rst_req",  64'(o_msi_req),  64'd0);
        check("rst_clr",  64'(o_clr),      64'd0);
        check("rst_busy", 64'(o_busy),     64'd0);
        check("rst_vec",  64'(o_msi_vec),  64'd0);
        check("rst_sent", 64'(o_sent_cnt), 64'd0);
        check("rst_drop", 64'(o_drop_cnt), 64'd0);
        i_rst = 1'b0;
        tick();

        // Single source, ack two cycles into the request.
        resp_en = 1'b1; resp_delay = 2;
        load(32'h4, '0);
        tick();
        check("latency_req", 64'(o_msi_req), 64'd1);
        check("single_vec",  64'(o_msi_vec), 64'd2);
        drain("single_drain");
        check("single_sent", 64'(o_sent_cnt), 64'd1);

        // Fairness from reset with pending flags held high.
        do_reset();
        resp_delay = 0;
        hold_pend  = 1'b1;
        i_pend = 32'h8000_0011;
        exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(31); exp_q.push_back(0);
        model_last = 0;
        clrs = 0; n = 0;
        while (clrs < 4 && n < 200) begin
            tick();
            n++;
            if (o_clr != '0) clrs++;
        end
        hold_pend = 1'b0;
        i_pend = '0;
        check("rr_grants", 64'(clrs), 64'd4);
        drain("rr_drain");

        // Masked source is never served.
        resp_delay = -1;
        load(32'h3, 32'h1);
        drain("mask_drain");
        check("mask_bit0_kept", 64'(i_pend), 64'h1);

        // Holdoff of 10 cycles between two serviced sources.
        i_holdoff_cyc = 16'd10;
        resp_delay = 0;
        load(32'h3, '0);
        c1 = -1; c2 = -1; n = 0;
        while (c2 < 0 && n < 300) begin
            tick();
            n++;
            if (c1 < 0) begin
                if (o_clr != '0) c1 = n;
            end else if (o_msi_req) begin
                c2 = n;
            end
        end
        check("holdoff_gap", 64'(c2 - c1), 64'd12);
        drain("holdoff_drain");
        i_holdoff_cyc = '0;

        // Every attempt fails.
        fail_pct = 100;
        rises0 = req_rises; sent0 = int'(o_sent_cnt); drop0 = int'(o_drop_cnt);
        load(32'h1, '0);
        drain("fail_drain");
        check("fail_requests", 64'(req_rises - rises0), 64'(MAX_TRY));
        check("fail_drop_inc", 64'(int'(o_drop_cnt) - drop0), 64'd1);
        check("fail_sent_same", 64'(o_sent_cnt), 64'(sent0));
        fail_pct = 0;

        // Ack and fail together count as sent.
        resp_both = 1'b1; resp_delay = 1;
        sent0 = int'(o_sent_cnt); drop0 = int'(o_drop_cnt);
        load(32'h20, '0);
        drain("both_drain");
        check("both_sent_inc", 64'(int'(o_sent_cnt) - sent0), 64'd1);
        check("both_drop_same", 64'(o_drop_cnt), 64'(drop0));
        resp_both = 1'b0;

        // Reset while a request is outstanding.
        resp_en = 1'b0;
        i_pend = 32'h2; i_mask = '0;
        tick();
        check("rstreq_up", 64'(o_msi_req), 64'd1);
        i_rst = 1'b1; i_pend = '0;
        tick();
        check("rstreq_drop", 64'(o_msi_req), 64'd0);
        check("rstreq_noclr", 64'(o_clr), 64'd0);
        tick();
        i_rst = 1'b0;
        model_last = DW - 1;
        tick();
        check("rstreq_busy", 64'(o_busy), 64'd0);
        check("rstreq_sent", 64'(o_sent_cnt), 64'd0);
        check("rstreq_noclr2", 64'(o_clr), 64'd0);
        resp_en = 1'b1;

        // Random batches against the reference model.
        resp_delay = -1; fail_pct = 25;
        for (int b = 0; b < 30; b++) begin
            i_holdoff_cyc = HW'($urandom_range(0, 5));
            p = $urandom & $urandom;
            if (b % 4 == 0) p = p & 32'h8000_00FF;
            m = $urandom & $urandom & $urandom;
            load(p, m);
            drain("rnd_drain");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
